// File: rtl/lcd_seq_pkg.sv
// Shared types for the LCD fill sequencer: FSM states, request packing and
// the rectangle sanity check applied when a request is popped.
package lcd_seq_pkg;

  localparam int COORD_W = 16;
  localparam int REG_W   = 32;
  localparam int REQ_W   = 4 * COORD_W;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_INIT     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_LOAD     = 3'd3,
    ST_FILL     = 3'd4
  } state_t;

  // Packing order {sc, ec, sp, ep}, sc in the most significant field.
  typedef struct packed {
    logic [COORD_W-1:0] sc;
    logic [COORD_W-1:0] ec;
    logic [COORD_W-1:0] sp;
    logic [COORD_W-1:0] ep;
  } req_t;

  function automatic logic rect_ok(input req_t r);
    return (r.ec >= r.sc) && (r.ep >= r.sp);
  endfunction

endpackage

// File: rtl/fill_req_fifo.sv
// Synchronous request FIFO with wrap-bit pointers, a flush that empties it in
// one cycle, and the head entry presented combinationally.
module fill_req_fifo
  import lcd_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = REQ_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_empty   = (r_wp == r_rp);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_data    = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + PW'(1);
      if (w_do_pop)  r_rp <= r_rp + PW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/lcd_fill_sequencer.sv
// Runs panel reset + init once, then drains queued rectangle fills into the
// LCD core one at a time, recovering from a stalled core by timeout.
module lcd_fill_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int RST_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 2**22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_sc,
  input  logic [COORD_W-1:0] req_ec,
  input  logic [COORD_W-1:0] req_sp,
  input  logic [COORD_W-1:0] req_ep,
  input  logic               reinit,
  input  logic               lcd_done,
  output logic               lcd_rstn,
  output logic               lcd_en,
  output logic               ini_en,
  output logic               color_en,
  output logic [REG_W-1:0]   set_sc,
  output logic [REG_W-1:0]   set_ec,
  output logic [REG_W-1:0]   set_sp,
  output logic [REG_W-1:0]   set_ep,
  output logic               busy,
  output logic               err_timeout,
  output logic               bad_rect
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  req_t               r_req;
  req_t               w_head;
  logic [REG_W-1:0]   r_set_sc, r_set_ec, r_set_sp, r_set_ep;
  logic               r_err_timeout;
  logic               w_full, w_empty;
  logic               w_push, w_pop, w_flush;
  logic               w_waiting, w_timeout, w_rect_ok;

  fill_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({req_sc, req_ec, req_sp, req_ep}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_waiting = (r_state == ST_INIT) || (r_state == ST_FILL);
  // A done pulse arriving on the last allowed cycle still counts as success.
  assign w_timeout = w_waiting && !lcd_done && (r_tmo_cnt == TMO_LAST);
  assign w_rect_ok = rect_ok(r_req);
  assign w_flush   = reinit || w_timeout;
  assign req_ready = !w_full && (r_state != ST_RST_HOLD);
  assign w_push    = req_valid && req_ready;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    if (reinit) begin
      w_state_nxt = ST_RST_HOLD;
    end else begin
      unique case (r_state)
        ST_RST_HOLD: if (r_hold_cnt == HOLD_LAST) w_state_nxt = ST_INIT;
        ST_INIT: begin
          if (lcd_done)       w_state_nxt = ST_IDLE;
          else if (w_timeout) w_state_nxt = ST_RST_HOLD;
        end
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_LOAD;
          end
        end
        ST_LOAD: w_state_nxt = w_rect_ok ? ST_FILL : ST_IDLE;
        ST_FILL: begin
          if (lcd_done)       w_state_nxt = ST_IDLE;
          else if (w_timeout) w_state_nxt = ST_RST_HOLD;
        end
        default: w_state_nxt = ST_RST_HOLD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RST_HOLD;
      r_hold_cnt    <= '0;
      r_tmo_cnt     <= '0;
      r_req         <= '0;
      r_set_sc      <= '0;
      r_set_ec      <= '0;
      r_set_sp      <= '0;
      r_set_ep      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // A reinit while already holding reset restarts the hold window.
      if (reinit || (r_state != w_state_nxt)) r_hold_cnt <= '0;
      else if (r_state == ST_RST_HOLD)        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);

      if (r_state != w_state_nxt) r_tmo_cnt <= '0;
      else if (w_waiting)         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (w_pop) r_req <= w_head;

      if ((r_state == ST_LOAD) && w_rect_ok && !reinit) begin
        r_set_sc <= REG_W'(r_req.sc);
        r_set_ec <= REG_W'(r_req.ec);
        r_set_sp <= REG_W'(r_req.sp);
        r_set_ep <= REG_W'(r_req.ep);
      end

      if (reinit)         r_err_timeout <= 1'b0;
      else if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign lcd_rstn    = (r_state != ST_RST_HOLD);
  assign lcd_en      = (r_state != ST_RST_HOLD);
  assign ini_en      = (r_state == ST_INIT);
  assign color_en    = (r_state == ST_FILL);
  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign bad_rect    = (r_state == ST_LOAD) && !w_rect_ok;
  assign err_timeout = r_err_timeout;
  assign set_sc      = r_set_sc;
  assign set_ec      = r_set_ec;
  assign set_sp      = r_set_sp;
  assign set_ep      = r_set_ep;

endmodule
